alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_ctrl_if.sv | 26 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared widths, opcodes, queue record layouts and FSM states for the ALU issue front end.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int TAG_W  = 4;
  localparam int INST_W = 3;

  localparam logic [INST_W-1:0] OP_NOP  = 3'd0;
  localparam logic [INST_W-1:0] OP_SUB  = 3'd1;  // B - A
  localparam logic [INST_W-1:0] OP_MUL  = 3'd2;
  localparam logic [INST_W-1:0] OP_NOT  = 3'd3;
  localparam logic [INST_W-1:0] OP_XOR  = 3'd4;
  localparam logic [INST_W-1:0] OP_ABS  = 3'd5;
  localparam logic [INST_W-1:0] OP_HSUB = 3'd6;  // arithmetic (B - A) >> 1
  localparam logic [INST_W-1:0] OP_ADD  = 3'd7;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [INST_W-1:0] inst;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Command and response handshake bundle between a client and alu_issue_ctrl.
interface alu_issue_ctrl_if;
  import alu_pkg::*;

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [DATA_W-1:0] cmd_a_i;
  logic [DATA_W-1:0] cmd_b_i;
  logic [INST_W-1:0] cmd_inst_i;
  logic [TAG_W-1:0]  cmd_tag_i;
  logic              flush_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [RES_W-1:0]  rsp_data_o;
  logic [TAG_W-1:0]  rsp_tag_o;

  modport master (
    output cmd_valid_i, cmd_a_i, cmd_b_i, cmd_inst_i, cmd_tag_i, flush_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
  );

  modport slave (
    input  cmd_valid_i, cmd_a_i, cmd_b_i, cmd_inst_i, cmd_tag_i, flush_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head, synchronous clear and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count = wr_ptr - rd_ptr;
  // Empty head reads as zero so downstream outputs are clean out of reset.
  assign rdata = (count == '0) ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clr && count == (AW+1)'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !clr && count == '0));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue front end for the 2-stage ALU: queues commands, tracks latency, returns tagged results in order.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int ALU_LAT   = 2
) (
  input  logic              clk_p_i,
  input  logic              reset_n_i,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [INST_W-1:0] alu_inst_o,
  input  logic [RES_W-1:0]  alu_data_i,
  output logic              busy_o
);
  localparam int          CAW        = $clog2(CMD_DEPTH);
  localparam int          RAW        = $clog2(RSP_DEPTH);
  localparam int unsigned PIPE_N     = ALU_LAT + 1;
  localparam int unsigned RSP_CREDIT = RSP_DEPTH;

  state_e           state_q;
  cmd_t             cmd_wdata;
  cmd_t             cmd_head;
  rsp_t             rsp_wdata;
  rsp_t             rsp_head;
  logic [CAW:0]     cmd_count;
  logic [RAW:0]     rsp_count;
  logic             cmd_full;
  logic             cmd_empty;
  logic             cmd_push;
  logic             issue;
  logic             credit_ok;
  logic             rsp_push;
  logic             rsp_pop;
  logic             rsp_valid;
  logic [ALU_LAT:0] pipe_v;
  logic [TAG_W-1:0] pipe_tag [PIPE_N];
  int unsigned      inflight;

  assign cmd_full       = (cmd_count == (CAW+1)'(CMD_DEPTH));
  assign cmd_empty      = (cmd_count == '0);
  assign bus.cmd_ready_o = reset_n_i && (state_q == RUN) && !cmd_full;
  assign cmd_push       = bus.cmd_valid_i && bus.cmd_ready_o && !bus.flush_i;
  assign cmd_wdata      = '{a: bus.cmd_a_i, b: bus.cmd_b_i, inst: bus.cmd_inst_i, tag: bus.cmd_tag_i};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_q (
    .clk   (clk_p_i),
    .rst_n (reset_n_i),
    .clr   (bus.flush_i),
    .push  (cmd_push),
    .wdata (cmd_wdata),
    .pop   (issue),
    .rdata (cmd_head),
    .count (cmd_count)
  );

  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < PIPE_N; i++) inflight += 32'(pipe_v[i]);
  end

  // A result handed off this edge frees its slot, so the pipe can stay full at 1 op/cycle.
  assign credit_ok = (32'(rsp_count) + inflight - 32'(rsp_pop)) < RSP_CREDIT;
  assign issue     = (state_q == RUN) && !bus.flush_i && !cmd_empty && credit_ok;

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < PIPE_N; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v      <= {pipe_v[ALU_LAT-1:0], issue};
      pipe_tag[0] <= cmd_head.tag;
      for (int unsigned i = 1; i < PIPE_N; i++) pipe_tag[i] <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_inst_o <= OP_NOP;
    end else if (issue) begin
      alu_a_o    <= cmd_head.a;
      alu_b_o    <= cmd_head.b;
      alu_inst_o <= cmd_head.inst;
    end else begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_inst_o <= OP_NOP;
    end
  end

  assign rsp_push  = pipe_v[ALU_LAT];
  assign rsp_wdata = '{data: alu_data_i, tag: pipe_tag[ALU_LAT]};
  assign rsp_valid = (rsp_count != '0);
  assign rsp_pop   = rsp_valid && bus.rsp_ready_i;

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_q (
    .clk   (clk_p_i),
    .rst_n (reset_n_i),
    .clr   (1'b0),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_head),
    .count (rsp_count)
  );

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_data_o  = rsp_head.data;
  assign bus.rsp_tag_o   = rsp_head.tag;

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (bus.flush_i) state_q <= DRAIN;
        DRAIN:   if (inflight == 0) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) busy_o <= 1'b0;
    else            busy_o <= !cmd_empty || (inflight != 0) || rsp_valid;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural 2-stage ALU and a response scoreboard.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic              clk_p_i = 1'b0;
  logic              reset_n_i;
  logic [DATA_W-1:0] alu_a_o;
  logic [DATA_W-1:0] alu_b_o;
  logic [INST_W-1:0] alu_inst_o;
  logic [RES_W-1:0]  alu_data_i = '0;
  logic              busy_o;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.CMD_DEPTH(4), .RSP_DEPTH(4), .ALU_LAT(2)) dut (
    .clk_p_i    (clk_p_i),
    .reset_n_i  (reset_n_i),
    .bus        (bus),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .alu_inst_o (alu_inst_o),
    .alu_data_i (alu_data_i),
    .busy_o     (busy_o)
  );

  always #5 clk_p_i = ~clk_p_i;

  // Behavioural ALU: operands registered at one edge, result presented after the next.
  function automatic logic [RES_W-1:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] op);
    logic signed [15:0] d;
    case (op)
      OP_ADD:  return {8'h00, a} + {8'h00, b};
      OP_SUB:  return {8'h00, b} - {8'h00, a};
      OP_MUL:  return {8'h00, a} * {8'h00, b};
      OP_NOT:  return {8'h00, ~a};
      OP_XOR:  return {8'h00, a ^ b};
      OP_ABS:  begin d = {{8{a[7]}}, a}; return (d < 0) ? -d : d; end
      OP_HSUB: begin d = {8'h00, b} - {8'h00, a}; return d >>> 1; end
      default: return '0;
    endcase
  endfunction

  logic [7:0] s1_a = '0, s1_b = '0;
  logic [2:0] s1_op = '0;
  always @(posedge clk_p_i) begin
    s1_a       <= alu_a_o;
    s1_b       <= alu_b_o;
    s1_op      <= alu_inst_o;
    alu_data_i <= alu_ref(s1_a, s1_b, s1_op);
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned hs_cnt = 0;
  int unsigned issue_cnt = 0;
  int unsigned hs_cyc[$];
  rsp_t        exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk_p_i) cyc <= cyc + 1;

  always @(negedge clk_p_i) begin
    if (reset_n_i && alu_inst_o != OP_NOP) issue_cnt++;
    if (reset_n_i && bus.rsp_valid_o && bus.rsp_ready_i) begin
      rsp_t e;
      hs_cnt++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rsp: got data %0h tag %0h, required no response",
                 bus.rsp_data_o, bus.rsp_tag_o);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data_tag", {bus.rsp_data_o, bus.rsp_tag_o}, {e.data, e.tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk_p_i);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] tag, input logic [15:0] exp);
    bit acc = 1'b0;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_a_i     = a;
    bus.cmd_b_i     = b;
    bus.cmd_inst_i  = op;
    bus.cmd_tag_i   = tag;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk_p_i);
      if (bus.cmd_ready_o) begin
        acc = 1'b1;
        exp_q.push_back('{data: exp, tag: tag});
      end
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int unsigned hs0, is0, acc;
    logic [7:0] ba, bb;

    tbl[0] = '{8'h03, 8'h05, OP_SUB,  4'h2, 16'h0002};
    tbl[1] = '{8'hFF, 8'hFF, OP_MUL,  4'h3, 16'hFE01};
    tbl[2] = '{8'h80, 8'h00, OP_ABS,  4'h4, 16'h0080};
    tbl[3] = '{8'hFF, 8'hFF, OP_ADD,  4'h5, 16'h01FE};
    tbl[4] = '{8'h05, 8'h03, OP_SUB,  4'h6, 16'hFFFE};
    tbl[5] = '{8'h0F, 8'h00, OP_NOT,  4'h7, 16'h00F0};
    tbl[6] = '{8'hA5, 8'h0F, OP_XOR,  4'h8, 16'h00AA};
    tbl[7] = '{8'h08, 8'h02, OP_HSUB, 4'h9, 16'hFFFD};
    tbl[8] = '{8'h85, 8'h00, OP_ABS,  4'hA, 16'h007B};
    tbl[9] = '{8'h12, 8'h34, OP_NOP,  4'hB, 16'h0000};

    reset_n_i       = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_a_i     = '0;
    bus.cmd_b_i     = '0;
    bus.cmd_inst_i  = '0;
    bus.cmd_tag_i   = '0;
    bus.flush_i     = 1'b0;
    bus.rsp_ready_i = 1'b0;
    #1 reset_n_i = 1'b0;
    #2;
    check("reset_outputs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_tag_o,
                            alu_a_o, alu_b_o, alu_inst_o, busy_o}, 64'd0);
    repeat (3) @(posedge clk_p_i);
    #1 reset_n_i = 1'b1;
    #1 check("ready_after_reset", 64'(bus.cmd_ready_o), 64'd1);

    // Single ADD: exact 4-cycle latency and NOP around the issue slot.
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b1;
    bus.cmd_a_i = 8'h05; bus.cmd_b_i = 8'h03; bus.cmd_inst_i = OP_ADD; bus.cmd_tag_i = 4'h1;
    @(negedge clk_p_i);
    check("add_ready", 64'(bus.cmd_ready_o), 64'd1);
    exp_q.push_back('{data: 16'h0008, tag: 4'h1});
    tick();
    bus.cmd_valid_i = 1'b0;
    check("add_nop_before", 64'(alu_inst_o), 64'(OP_NOP));
    tick();
    check("add_issue", {alu_inst_o, alu_a_o, alu_b_o}, {OP_ADD, 8'h05, 8'h03});
    tick();
    check("add_nop_after", 64'(alu_inst_o), 64'(OP_NOP));
    tick();
    check("add_rsp_not_early", 64'(bus.rsp_valid_o), 64'd0);
    tick();
    check("add_rsp_at_e4", 64'(bus.rsp_valid_o), 64'd1);
    check("add_busy", 64'(busy_o), 64'd1);
    wait_drain();
    repeat (2) tick();
    check("idle_not_busy", 64'(busy_o), 64'd0);

    // Table vectors back-to-back: results in order on consecutive cycles.
    hs0 = hs_cyc.size();
    foreach (tbl[i]) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, tbl[i].exp);
    wait_drain();
    check("b2b_throughput", 64'(hs_cyc[hs0 + 9] - hs_cyc[hs0]), 64'd9);

    // Response backpressure: 4 issues, 8 accepts, then stall.
    repeat (2) tick();
    bus.rsp_ready_i = 1'b0;
    hs0 = hs_cnt;
    is0 = issue_cnt;
    acc = 0;
    for (int k = 0; k < 16; k++) begin
      ba = 8'(acc * 17);
      bb = 8'(acc + 100);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_a_i = ba; bus.cmd_b_i = bb; bus.cmd_inst_i = OP_ADD; bus.cmd_tag_i = 4'(acc);
      @(negedge clk_p_i);
      if (bus.cmd_ready_o) begin
        exp_q.push_back('{data: {8'h00, ba} + {8'h00, bb}, tag: 4'(acc)});
        acc++;
      end
      tick();
    end
    bus.cmd_valid_i = 1'b0;
    check("bp_accepts", 64'(acc), 64'd8);
    check("bp_issues", 64'(issue_cnt - is0), 64'd4);
    check("bp_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    check("bp_no_handshake", 64'(hs_cnt - hs0), 64'd0);
    check("bp_head_held", {bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_tag_o}, {1'b1, 16'h0064, 4'h0});
    bus.rsp_ready_i = 1'b1;
    for (int j = 8; j < 10; j++)
      send(8'(j * 17), 8'(j + 100), OP_ADD, 4'(j), 16'(j * 17) + 16'(j + 100));
    wait_drain();
    check("bp_all_results", 64'(hs_cnt - hs0), 64'd10);

    // Flush with results pending, two in flight, two queued and a colliding accept.
    repeat (2) tick();
    bus.rsp_ready_i = 1'b0;
    hs0 = hs_cnt;
    send(8'h10, 8'h01, OP_ADD, 4'h1, 16'h0011);
    send(8'h20, 8'h02, OP_ADD, 4'h2, 16'h0022);
    repeat (6) tick();
    send(8'h30, 8'h03, OP_ADD, 4'h3, 16'h0033);
    send(8'h40, 8'h04, OP_ADD, 4'h4, 16'h0044);
    send(8'h50, 8'h05, OP_ADD, 4'h5, 16'h0055);
    send(8'h60, 8'h06, OP_ADD, 4'h6, 16'h0066);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    bus.cmd_valid_i = 1'b1;
    bus.cmd_a_i = 8'h70; bus.cmd_b_i = 8'h07; bus.cmd_inst_i = OP_ADD; bus.cmd_tag_i = 4'h7;
    bus.flush_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    is0 = issue_cnt;
    check("flush_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    check("drain_ready_low", 64'(bus.cmd_ready_o), 64'd0);
    tick();
    check("drain_ready_back", 64'(bus.cmd_ready_o), 64'd1);
    bus.rsp_ready_i = 1'b1;
    wait_drain();
    repeat (6) tick();
    check("flush_no_issue", 64'(issue_cnt - is0), 64'd0);
    check("flush_delivered", 64'(hs_cnt - hs0), 64'd4);

    // Flush colliding with an accept while idle.
    hs0 = hs_cnt;
    is0 = issue_cnt;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_a_i = 8'h11; bus.cmd_b_i = 8'h22; bus.cmd_inst_i = OP_ADD; bus.cmd_tag_i = 4'hF;
    bus.flush_i = 1'b1;
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (10) tick();
    check("collide_no_rsp", 64'(hs_cnt - hs0), 64'd0);
    check("collide_no_issue", 64'(issue_cnt - is0), 64'd0);
    check("collide_idle", 64'(busy_o), 64'd0);

    // Reset in the middle of a stream.
    send(8'h01, 8'h02, OP_ADD, 4'h1, 16'h0003);
    send(8'h03, 8'h04, OP_ADD, 4'h2, 16'h0007);
    send(8'h05, 8'h06, OP_ADD, 4'h3, 16'h000B);
    reset_n_i = 1'b0;
    #1;
    check("midreset_outputs", {bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_tag_o,
                               alu_a_o, alu_b_o, alu_inst_o, busy_o}, 64'd0);
    exp_q.delete();
    @(posedge clk_p_i);
    #1 reset_n_i = 1'b1;
    #1 check("midreset_ready", 64'(bus.cmd_ready_o), 64'd1);
    hs0 = hs_cnt;
    tick();
    send(8'h01, 8'h01, OP_ADD, 4'h9, 16'h0002);
    wait_drain();
    repeat (6) tick();
    check("midreset_single_rsp", 64'(hs_cnt - hs0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
